// File: rtl/fc_params_pkg.sv
`default_nettype none
// ============================================================================
// Package : fc_params_pkg
// Brief   : Shared FC2 dimensions and the parameter-writer state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package fc_params_pkg;

  localparam int FC2_IN_DIM  = 32;
  localparam int FC2_OUT_DIM = 10;
  localparam int FC2_W_DEPTH = FC2_IN_DIM * FC2_OUT_DIM;
  localparam int FC2_B_DEPTH = FC2_OUT_DIM;

  localparam logic [2:0] FC2_ST_IDLE    = 3'd0;
  localparam logic [2:0] FC2_ST_WEIGHTS = 3'd1;
  localparam logic [2:0] FC2_ST_BIAS    = 3'd2;
  localparam logic [2:0] FC2_ST_CHECK   = 3'd3;
  localparam logic [2:0] FC2_ST_DONE    = 3'd4;
  localparam logic [2:0] FC2_ST_ERR     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = FC2_ST_IDLE,
    S_WEIGHTS = FC2_ST_WEIGHTS,
    S_BIAS    = FC2_ST_BIAS,
    S_CHECK   = FC2_ST_CHECK,
    S_DONE    = FC2_ST_DONE,
    S_ERR     = FC2_ST_ERR
  } fc2_state_e;

endpackage
`default_nettype wire

// File: rtl/fc2_param_writer.sv
`default_nettype none
// ============================================================================
// Module : fc2_param_writer
// Brief  : Streams FC2 weights then biases into their RAM write ports and
//          closes the load with an optional 8-bit additive checksum.
// Rev    : 1.0 - initial release
// ============================================================================
module fc2_param_writer
  import fc_params_pkg::*;
#(
  parameter int IN_DIM       = FC2_IN_DIM,
  parameter int OUT_DIM      = FC2_OUT_DIM,
  parameter int DATA_WIDTH   = 8,
  parameter int W_ADDR_WIDTH = 9,
  parameter int B_ADDR_WIDTH = 4,
  parameter bit CHECKSUM_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    w_we,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0]   w_wdata,
  output logic                    b_we,
  output logic [B_ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [W_ADDR_WIDTH-1:0] W_LAST = W_ADDR_WIDTH'(IN_DIM * OUT_DIM - 1);
  localparam logic [B_ADDR_WIDTH-1:0] B_LAST = B_ADDR_WIDTH'(OUT_DIM - 1);
  localparam logic [W_ADDR_WIDTH-1:0] W_ONE  = W_ADDR_WIDTH'(1);
  localparam logic [B_ADDR_WIDTH-1:0] B_ONE  = B_ADDR_WIDTH'(1);

  fc2_state_e                  state_q;
  logic [W_ADDR_WIDTH-1:0]     w_idx_q;
  logic [B_ADDR_WIDTH-1:0]     b_idx_q;
  logic [DATA_WIDTH-1:0]       sum_q;
  logic [DATA_WIDTH-1:0]       sum_d;
  logic                        w_we_q, b_we_q, done_q, error_q;
  logic [W_ADDR_WIDTH-1:0]     w_addr_q;
  logic [B_ADDR_WIDTH-1:0]     b_addr_q;
  logic [DATA_WIDTH-1:0]       w_wdata_q, b_wdata_q;
  logic                        loading;
  logic                        accept;

  // Ready is a pure state decode so s_valid never reaches s_ready.
  assign loading = (state_q == S_WEIGHTS) || (state_q == S_BIAS) || (state_q == S_CHECK);
  assign accept  = s_valid & loading;
  assign sum_d   = sum_q + s_data;

  always_ff @(posedge clk) begin
    w_we_q <= 1'b0;
    b_we_q <= 1'b0;
    if (rst) begin
      state_q   <= S_IDLE;
      w_idx_q   <= '0;
      b_idx_q   <= '0;
      sum_q     <= '0;
      w_addr_q  <= '0;
      w_wdata_q <= '0;
      b_addr_q  <= '0;
      b_wdata_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else if (start) begin
      // Start from any state (including abort mid-load) drops any byte offered this cycle.
      state_q <= S_WEIGHTS;
      w_idx_q <= '0;
      b_idx_q <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_WEIGHTS: if (accept) begin
          w_we_q    <= 1'b1;
          w_addr_q  <= w_idx_q;
          w_wdata_q <= s_data;
          sum_q     <= sum_d;
          if (w_idx_q == W_LAST) state_q <= S_BIAS;
          else                   w_idx_q <= w_idx_q + W_ONE;
        end
        S_BIAS: if (accept) begin
          b_we_q    <= 1'b1;
          b_addr_q  <= b_idx_q;
          b_wdata_q <= s_data;
          sum_q     <= sum_d;
          if (b_idx_q == B_LAST) begin
            if (CHECKSUM_EN) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            b_idx_q <= b_idx_q + B_ONE;
          end
        end
        S_CHECK: if (accept) begin
          if (s_data == sum_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ERR;
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready = loading;
  assign busy    = loading;
  assign w_we    = w_we_q;
  assign w_addr  = w_addr_q;
  assign w_wdata = w_wdata_q;
  assign b_we    = b_we_q;
  assign b_addr  = b_addr_q;
  assign b_wdata = b_wdata_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fc2_param_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_fc2_param_writer
// Brief  : Scoreboard bench for fc2_param_writer (checksum on and off builds).
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fc2_param_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, s_valid;
  logic [7:0] s_data;
  logic       s_ready, w_we, b_we, busy, done, error;
  logic [8:0] w_addr;
  logic [3:0] b_addr;
  logic [7:0] w_wdata, b_wdata;

  logic       start1, s_valid1;
  logic [7:0] s_data1;
  logic       s_ready1, w_we1, b_we1, busy1, done1, error1;
  logic [8:0] w_addr1;
  logic [3:0] b_addr1;
  logic [7:0] w_wdata1, b_wdata1;

  // Hand-computed: sum(0..255)+sum(0..63)+sum(0xF6..0xFF) mod 256 = 0x29
  localparam logic [7:0] c_SUM = 8'h29;

  always #5 clk = ~clk;

  fc2_param_writer #(
    .IN_DIM(32), .OUT_DIM(10), .DATA_WIDTH(8), .W_ADDR_WIDTH(9), .B_ADDR_WIDTH(4), .CHECKSUM_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .busy(busy), .done(done), .error(error)
  );

  fc2_param_writer #(
    .IN_DIM(32), .OUT_DIM(10), .DATA_WIDTH(8), .W_ADDR_WIDTH(9), .B_ADDR_WIDTH(4), .CHECKSUM_EN(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid1), .s_data(s_data1), .s_ready(s_ready1),
    .w_we(w_we1), .w_addr(w_addr1), .w_wdata(w_wdata1), .b_we(b_we1), .b_addr(b_addr1), .b_wdata(b_wdata1),
    .busy(busy1), .done(done1), .error(error1)
  );

  typedef struct {
    bit   bias;
    int   addr;
    int   data;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_wr  = 0;
  int   w1_cnt = 0, b1_cnt = 0, w1_last = -1, b1_last = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write, including its cycle.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && (w_we === 1'b1 || b_we === 1'b1)) begin
      n_wr++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: w_we=%0b w_addr=%0d b_we=%0b b_addr=%0d, no write expected (cycle %0d)",
                 w_we, w_addr, b_we, b_addr, cyc);
      end else begin
        e = q.pop_front();
        if ((w_we && b_we) || (b_we !== e.bias) ||
            ((b_we ? int'(b_addr) : int'(w_addr)) != e.addr) ||
            ((b_we ? int'(b_wdata) : int'(w_wdata)) != e.data) || (cyc != e.cyc)) begin
          n_err++;
          $display("FAIL write: got w_we=%0b b_we=%0b addr=%0d data=%0h cyc=%0d, expected bias=%0b addr=%0d data=%0h cyc=%0d",
                   w_we, b_we, b_we ? int'(b_addr) : int'(w_addr), b_we ? b_wdata : w_wdata, cyc,
                   e.bias, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_we1 === 1'b1) begin w1_cnt++; w1_last = int'(w_addr1); end
    if (!rst && b_we1 === 1'b1) begin b1_cnt++; b1_last = int'(b_addr1); end
  end

  // Called at a negedge; returns at the following negedge with s_valid low.
  task automatic send(input logic [7:0] d, input bit push, input bit bias, input int addr);
    exp_t x;
    s_valid = 1'b1;
    s_data  = d;
    chk("s_ready_load", s_ready, 1);
    if (push) begin
      x.bias = bias; x.addr = addr; x.data = int'(d); x.cyc = cyc + 1;
      q.push_back(x);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic gap(input int gmax);
    if (gmax > 0) repeat ($urandom_range(0, gmax)) @(negedge clk);
  endtask

  // Start pulse with a byte offered alongside; that byte must never be written.
  task automatic do_start();
    start = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("flags_cleared", {done, error}, 0);
  endtask

  task automatic stream(input int gmax, input logic [7:0] cx);
    logic [31:0] iv;
    for (int i = 0; i < 320; i++) begin
      iv = i;
      gap(gmax);
      send(iv[7:0], 1'b1, 1'b0, i);
    end
    for (int k = 0; k < 10; k++) begin
      iv = 32'hF6 + k;
      gap(gmax);
      send(iv[7:0], 1'b1, 1'b1, k);
    end
    gap(gmax);
    send(c_SUM ^ cx, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iv;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    start1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {s_ready, w_we, b_we, busy, done, error}, 0);
    chk("reset_w", {w_addr, w_wdata}, 0);
    chk("reset_b", {b_addr, b_wdata}, 0);
    rst = 1'b0;

    // Bytes offered in IDLE are refused.
    s_valid = 1'b1; s_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_s_ready", s_ready, 0);
    end
    s_valid = 1'b0;

    // Nominal load.
    do_start();
    stream(0, 8'h00);
    chk("nom_done_error", {done, error}, 2'b10);
    chk("nom_ready_busy", {s_ready, busy}, 0);

    // Bad checksum: all writes still issued, error raised.
    do_start();
    stream(0, 8'h01);
    chk("bad_done_error", {done, error}, 2'b01);
    chk("bad_ready_busy", {s_ready, busy}, 0);

    // Random stalls between bytes.
    do_start();
    stream(5, 8'h00);
    chk("gap_done_error", {done, error}, 2'b10);

    // Abort after 100 weights with a byte offered in the start cycle.
    do_start();
    for (int i = 0; i < 100; i++) begin
      iv = i;
      send(iv[7:0], 1'b1, 1'b0, i);
    end
    start = 1'b1; s_valid = 1'b1; s_data = 8'h64;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
    chk("abort_busy", busy, 1);
    stream(0, 8'h00);
    chk("abort_done_error", {done, error}, 2'b10);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("total_writes", n_wr, 4 * 330 + 100);

    // Checksum disabled: done right after the last bias, next byte refused.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 330; i++) begin
      iv = i;
      s_valid1 = 1'b1; s_data1 = iv[7:0];
      @(negedge clk);
    end
    chk("nocs_done_error", {done1, error1}, 2'b10);
    chk("nocs_ready_busy", {s_ready1, busy1}, 0);
    s_data1 = 8'hEE;
    repeat (3) @(negedge clk);
    s_valid1 = 1'b0;
    chk("nocs_ready_after", s_ready1, 0);
    chk("nocs_w_count", w1_cnt, 320);
    chk("nocs_b_count", b1_cnt, 10);
    chk("nocs_last_addrs", {w1_last[15:0], b1_last[15:0]}, {16'd319, 16'd9});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
